// File: rtl/burst_ram.sv
// Avalon RAM slave with byte lanes, fixed-length read/write bursts and a
// 1- or 2-cycle pipelined read path flagged by readdatavalid.
module burst_ram #(
  parameter int ADDR_SEL_BITS = 6,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 256,
  parameter int BURST_BITS    = 4,
  parameter int READ_LATENCY  = 1
) (
  input  logic                        i_Clk,
  input  logic                        i_Rst_n,
  input  logic                        i_SlaveSel,
  input  logic [30-ADDR_SEL_BITS-1:0] i_RegAddr,
  input  logic [DATA_WIDTH/8-1:0]     i_AV_ByteEn,
  input  logic                        i_AV_Read,
  input  logic                        i_AV_Write,
  input  logic [BURST_BITS-1:0]       i_AV_BurstCount,
  input  logic [DATA_WIDTH-1:0]       i_AV_WriteData,
  output logic [DATA_WIDTH-1:0]       o_AV_ReadData,
  output logic                        o_AV_ReadDataValid,
  output logic                        o_AV_WaitRequest
);
  localparam int AW  = $clog2(DEPTH);
  localparam int NB  = DATA_WIDTH / 8;
  localparam int RAW = 30 - ADDR_SEL_BITS;

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST} state_e;

  state_e                state_q, state_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [BURST_BITS-1:0] rem_q, rem_d;
  logic                  wait_q, wait_d;

  logic                  rd_en, wr_en;
  logic [AW-1:0]         ram_addr, cmd_addr;
  logic [BURST_BITS-1:0] cnt;
  logic [NB-1:0][7:0]    ram_rd;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [READ_LATENCY-1:0] vld_pipe_q;

  assign cnt      = (i_AV_BurstCount == '0) ? BURST_BITS'(1) : i_AV_BurstCount;
  assign cmd_addr = i_RegAddr[AW-1:0];

  // Reads and writes never share a cycle, so one RAM address serves both.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    rd_en    = 1'b0;
    wr_en    = 1'b0;
    ram_addr = addr_q;
    case (state_q)
      IDLE: begin
        if (i_SlaveSel && i_AV_Read) begin
          rd_en    = 1'b1;
          ram_addr = cmd_addr;
          if (cnt > BURST_BITS'(1)) begin
            state_d = RD_BURST;
            addr_d  = cmd_addr + 1'b1;
            rem_d   = cnt - BURST_BITS'(1);
          end
        end else if (i_SlaveSel && i_AV_Write) begin
          wr_en    = 1'b1;
          ram_addr = cmd_addr;
          if (cnt > BURST_BITS'(1)) begin
            state_d = WR_BURST;
            addr_d  = cmd_addr + 1'b1;
            rem_d   = cnt - BURST_BITS'(1);
          end
        end
      end
      RD_BURST: begin
        rd_en  = 1'b1;
        addr_d = addr_q + 1'b1;
        rem_d  = rem_q - BURST_BITS'(1);
        if (rem_q <= BURST_BITS'(1)) state_d = IDLE;
      end
      WR_BURST: begin
        if (i_SlaveSel && i_AV_Write) begin
          wr_en  = 1'b1;
          addr_d = addr_q + 1'b1;
          rem_d  = rem_q - BURST_BITS'(1);
          if (rem_q <= BURST_BITS'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    wait_d = (state_d == RD_BURST);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      wait_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      wait_q  <= wait_d;
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_q;
    always_ff @(posedge i_Clk) begin
      if (wr_en && i_AV_ByteEn[b]) mem[ram_addr] <= i_AV_WriteData[8*b +: 8];
      if (rd_en) rd_q <= mem[ram_addr];
    end
    assign ram_rd[b] = rd_q;
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] out_q;
    always_ff @(posedge i_Clk) out_q <= ram_rd;
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) vld_pipe_q <= '0;
      else          vld_pipe_q <= {vld_pipe_q[0], rd_en};
    end
    assign rd_data = out_q;
  end else begin : g_lat1
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) vld_pipe_q <= '0;
      else          vld_pipe_q <= rd_en;
    end
    assign rd_data = ram_rd;
  end

  if (RAW > AW) begin : g_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^i_RegAddr[RAW-1:AW];
  end

  assign o_AV_ReadDataValid = vld_pipe_q[READ_LATENCY-1];
  assign o_AV_ReadData      = o_AV_ReadDataValid ? rd_data : '0;
  assign o_AV_WaitRequest   = wait_q;
endmodule
